// File: rtl/ntt_butterfly_addsub_if.sv
// Port bundle for the butterfly add/sub stage: issue side, multiplier return and results.
// The slave modport is the butterfly stage; the master modport is whatever drives it.
interface ntt_butterfly_addsub_if #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 7
) ();

    logic                  i_enable;
    logic                  i_valid_in;
    logic [DATA_WIDTH-1:0] i_a_in;
    logic [ADDR_WIDTH-1:0] i_addr_in;
    logic [DATA_WIDTH-1:0] i_mul_result;
    logic                  i_mul_valid;
    logic                  i_stage_clr;

    logic [DATA_WIDTH-1:0] o_sum_out;
    logic [DATA_WIDTH-1:0] o_diff_out;
    logic [ADDR_WIDTH-1:0] o_addr_out;
    logic                  o_valid_out;
    logic                  o_stage_done;
    logic [ADDR_WIDTH:0]   o_bf_count;
    logic                  o_align_err;

    modport slave (
        input  i_enable, i_valid_in, i_a_in, i_addr_in,
        input  i_mul_result, i_mul_valid, i_stage_clr,
        output o_sum_out, o_diff_out, o_addr_out, o_valid_out,
        output o_stage_done, o_bf_count, o_align_err
    );

    modport master (
        output i_enable, i_valid_in, i_a_in, i_addr_in,
        output i_mul_result, i_mul_valid, i_stage_clr,
        input  o_sum_out, o_diff_out, o_addr_out, o_valid_out,
        input  o_stage_done, o_bf_count, o_align_err
    );

endinterface

// File: rtl/ntt_butterfly_addsub.sv
// Kyber NTT butterfly back end: delays operand a to meet the multiplier result t,
// then registers (a+t) mod q and (a-t) mod q, counts butterflies and flags path skew.
module ntt_butterfly_addsub #(
    parameter int DATA_WIDTH   = 12,
    parameter int MODULUS      = 3329,
    parameter int MUL_LATENCY  = 5,
    parameter int ADDR_WIDTH   = 7,
    parameter int BF_PER_STAGE = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ntt_butterfly_addsub_if.slave  bus
);

    localparam int                  CW      = ADDR_WIDTH + 1;
    localparam logic [DATA_WIDTH:0] LP_Q    = (DATA_WIDTH + 1)'(MODULUS);
    localparam logic [CW-1:0]       LP_LAST = CW'(BF_PER_STAGE - 1);
    localparam logic [CW-1:0]       LP_ONE  = CW'(1);

    logic [MUL_LATENCY-1:0][DATA_WIDTH-1:0] r_aDly;
    logic [MUL_LATENCY-1:0][ADDR_WIDTH-1:0] r_addrDly;
    logic [MUL_LATENCY-1:0]                 r_vDly;

    logic [DATA_WIDTH-1:0] r_sum;
    logic [DATA_WIDTH-1:0] r_diff;
    logic [ADDR_WIDTH-1:0] r_addrOut;
    logic                  r_validOut;
    logic                  r_stageDone;
    logic [CW-1:0]         r_bfCount;
    logic                  r_alignErr;

    logic                  w_issue;
    logic                  w_delayedValid;
    logic [DATA_WIDTH-1:0] w_aDelayed;
    logic [ADDR_WIDTH-1:0] w_addrDelayed;
    logic                  w_mismatch;
    logic                  w_fire;
    logic [DATA_WIDTH:0]   w_sumRaw;
    logic [DATA_WIDTH:0]   w_diffRaw;
    logic [DATA_WIDTH-1:0] w_sumNext;
    logic [DATA_WIDTH-1:0] w_diffNext;
    logic                  w_lastBf;

    assign w_issue        = bus.i_enable & bus.i_valid_in;
    assign w_delayedValid = r_vDly[MUL_LATENCY-1];
    assign w_aDelayed     = r_aDly[MUL_LATENCY-1];
    assign w_addrDelayed  = r_addrDly[MUL_LATENCY-1];

    // A cycle where only one path is valid is a skew error and produces no result.
    assign w_mismatch = bus.i_mul_valid ^ w_delayedValid;
    assign w_fire     = bus.i_mul_valid & w_delayedValid;

    // a + q - t stays non-negative for in-range t, so one conditional subtract suffices.
    assign w_sumRaw   = {1'b0, w_aDelayed} + {1'b0, bus.i_mul_result};
    assign w_diffRaw  = {1'b0, w_aDelayed} + LP_Q - {1'b0, bus.i_mul_result};
    assign w_sumNext  = DATA_WIDTH'((w_sumRaw  >= LP_Q) ? (w_sumRaw  - LP_Q) : w_sumRaw);
    assign w_diffNext = DATA_WIDTH'((w_diffRaw >= LP_Q) ? (w_diffRaw - LP_Q) : w_diffRaw);

    assign w_lastBf = (r_bfCount == LP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aDly    <= '0;
            r_addrDly <= '0;
            r_vDly    <= '0;
        end else begin
            r_aDly[0]    <= bus.i_a_in;
            r_addrDly[0] <= bus.i_addr_in;
            r_vDly[0]    <= w_issue;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                r_aDly[i]    <= r_aDly[i-1];
                r_addrDly[i] <= r_addrDly[i-1];
                r_vDly[i]    <= r_vDly[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum      <= '0;
            r_diff     <= '0;
            r_addrOut  <= '0;
            r_validOut <= 1'b0;
            r_alignErr <= 1'b0;
        end else begin
            r_validOut <= w_fire;
            r_alignErr <= r_alignErr | w_mismatch;
            if (w_fire) begin
                r_sum     <= w_sumNext;
                r_diff    <= w_diffNext;
                r_addrOut <= w_addrDelayed;
            end
        end
    end

    // stage_clr wins over a concurrent increment: the result still goes out uncounted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bfCount   <= '0;
            r_stageDone <= 1'b0;
        end else begin
            r_stageDone <= 1'b0;
            if (bus.i_stage_clr) begin
                r_bfCount <= '0;
            end else if (w_fire && w_lastBf) begin
                r_bfCount   <= '0;
                r_stageDone <= 1'b1;
            end else if (w_fire) begin
                r_bfCount <= r_bfCount + LP_ONE;
            end
        end
    end

    assign bus.o_sum_out    = r_sum;
    assign bus.o_diff_out   = r_diff;
    assign bus.o_addr_out   = r_addrOut;
    assign bus.o_valid_out  = r_validOut;
    assign bus.o_stage_done = r_stageDone;
    assign bus.o_bf_count   = r_bfCount;
    assign bus.o_align_err  = r_alignErr;

endmodule
